multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter MEM_LATENCY, default 1, giving the cycles per memory-access state (legal range 1..15).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port EN, input, 1 bit: advance enable; low means stall.
REQ-005 The block SHALL have inputs OP (7 bits, Instr[6:0]), funct3 (3 bits), funct7 (1 bit, Instr[30]) and Zero (1 bit, ALU zero flag).
REQ-006 The block SHALL have 1-bit outputs PCWrite, AdrSrc, MemWrite, IRWrite and RegWrite.
REQ-007 The block SHALL have 2-bit outputs ResultSrc, ALUSrcA, ALUSrcB and ImmSrc, and 3-bit output ALUControl.
REQ-008 The block SHALL have output IllegalInstr (1 bit, one-cycle pulse) and output State (4 bits, current state code).

Function
REQ-009 Mux encodings SHALL be:
- ALUSrcA: 00 PC, 01 OldPC, 10 register A.
- ALUSrcB: 00 WriteData, 01 ImmExt, 10 constant 4.
- ResultSrc: 00 ALUOut, 01 Data, 10 ALUResult.
- AdrSrc: 0 PC, 1 Result.
REQ-010 ALUControl codes SHALL be 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-011 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ and JAL.
REQ-012 Transitions SHALL be:
- FETCH->DECODE.
- DECODE: lw(0000011)/sw(0100011)->MEMADR; R(0110011)->EXECUTER; I(0010011)->EXECUTEI; 1101111->JAL; 1100011->BEQ.
- MEMADR: ->MEMREAD for lw, ->MEMWRITE for sw. MEMREAD->MEMWB->FETCH. MEMWRITE->FETCH.
- EXECUTER/EXECUTEI->ALUWB. JAL->ALUWB. ALUWB->FETCH. BEQ->FETCH.
REQ-013 Any other OP in DECODE SHALL return to FETCH and pulse IllegalInstr high for that DECODE cycle, with no write enable asserted.
REQ-014 FETCH, MEMREAD and MEMWRITE SHALL each dwell MEM_LATENCY cycles, tracked by a 4-bit counter that clears on state exit.
- FETCH IRWrite/PCWrite, and MEMWRITE MemWrite, SHALL assert only on the final dwell cycle.
- MEM_LATENCY=1 SHALL give exactly one cycle per state.
REQ-015 Outputs per state SHALL be:
- FETCH: AdrSrc0, ALUSrcA00, ALUSrcB10, add, ResultSrc10.
- DECODE: ALUSrcA01, ALUSrcB01, add.
- MEMADR: ALUSrcA10, ALUSrcB01, add.
- MEMREAD: ResultSrc00, AdrSrc1.
- MEMWB: ResultSrc01, RegWrite.
- MEMWRITE: ResultSrc00, AdrSrc1, MemWrite.
- EXECUTER: ALUSrcA10, ALUSrcB00, decoded ALUControl.
- EXECUTEI: ALUSrcA10, ALUSrcB01, decoded ALUControl.
- ALUWB: ResultSrc00, RegWrite.
- BEQ: ALUSrcA10, ALUSrcB00, sub, ResultSrc00, PCWrite=Zero.
- JAL: ALUSrcA01, ALUSrcB10, add, ResultSrc00, PCWrite.
- All unlisted outputs SHALL be 0.
REQ-016 ALU decode SHALL map funct3 as follows:
- 000: sub if R-type and funct7=1, else add.
- 010: slt. 110: or. 111: and.
- Other funct3 values: add, plus an IllegalInstr pulse in EXECUTER/EXECUTEI.
REQ-017 ImmSrc SHALL be combinational from OP: I 00, S 01, B 10, J 11; 00 otherwise.
REQ-018 When EN=0, state and counter SHALL hold, and PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced 0; mux selects SHALL still track the state.
REQ-019 All outputs SHALL be Moore outputs (state/counter, plus OP/funct decode), except PCWrite in BEQ, which uses Zero combinationally.

Reset
REQ-020 RESET low SHALL immediately force state FETCH, counter 0 and every write enable and IllegalInstr to 0, including mid-MEMWRITE.
REQ-021 The first FETCH dwell SHALL begin on the first rising CLK edge after RESET deasserts.

Configuration
REQ-022 With MULTICYCLE_CTRL_BNE_EN defined, the BEQ state SHALL also serve funct3=001 (bne), with PCWrite=~Zero.
REQ-023 Without MULTICYCLE_CTRL_BNE_EN, branch funct3 other than 000 SHALL behave as beq and SHALL NOT pulse IllegalInstr.

Structure
REQ-024 Package riscv_ctrl_pkg SHALL hold the state encoding, opcode constants, ALUControl codes and mux-select constants.
REQ-025 The ALU decode of REQ-016 SHALL be a sub-module named alu_decoder, instantiated once.

Verification
REQ-026 Reset then EN=1, MEM_LATENCY=1, OP=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite=1 only in MEMWB.
REQ-027 MEM_LATENCY=3, OP=0100011 -> FETCH lasts 3 cycles with IRWrite on cycle 3 only; MEMWRITE lasts 3 cycles with MemWrite on cycle 3 only.
REQ-028 OP=0110011, funct3=000, funct7=1 -> ALUControl=001 in EXECUTER; funct7=0 -> 000.
REQ-029 BEQ with Zero=1 -> PCWrite=1; with Zero=0 -> PCWrite=0; with the macro defined and funct3=001, the result is inverted.
REQ-030 OP=1111111 -> IllegalInstr pulses 1 cycle in DECODE, then FETCH.
REQ-031 EN=0 for 2 cycles in MEMWB -> State holds and RegWrite=0; RESET low in MEMWRITE -> MemWrite=0 before the next CLK edge.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: state codes, opcodes,
// ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;
    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_RESULT = 1'b1;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        logic [1:0] sel;
        case (op)
            OP_I:    sel = IMM_I;
            OP_SW:   sel = IMM_S;
            OP_BR:   sel = IMM_B;
            OP_JAL:  sel = IMM_J;
            default: sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Instruction fields in, datapath controls out. master = controller side,
// slave = datapath side.
interface multicycle_controller_if;
    logic [6:0] OP;
    logic [2:0] funct3;
    logic       funct7;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       IllegalInstr;
    logic [3:0] State;

    modport master (
        input  OP, funct3, funct7, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr, State
    );
    modport slave (
        output OP, funct3, funct7, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr, State
    );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decode from funct3/funct7; purely combinational, flags
// funct3 values the ALU does not implement.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic       i_is_rtype,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7,
    output logic [2:0] o_alu_control,
    output logic       o_illegal
);
    always_comb begin
        o_alu_control = ALU_ADD;
        o_illegal     = 1'b0;
        case (i_funct3)
            3'b000:  o_alu_control = (i_is_rtype && i_funct7) ? ALU_SUB : ALU_ADD;
            3'b010:  o_alu_control = ALU_SLT;
            3'b110:  o_alu_control = ALU_OR;
            3'b111:  o_alu_control = ALU_AND;
            default: o_illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM; Moore outputs, memory states dwell MEM_LATENCY cycles.
// EN=0 stalls and masks write enables. MULTICYCLE_CTRL_BNE_EN adds bne to the BEQ state.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic EN,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    state_t     r_state, w_next;
    logic [3:0] r_cnt;
    logic       w_last, w_gate, w_beq_take;
    logic [2:0] w_dec_alu;
    logic       w_dec_illegal;
    logic       w_pcwrite, w_memwrite, w_irwrite, w_regwrite, w_illegal, w_adrsrc;
    logic [1:0] w_resultsrc, w_srca, w_srcb;
    logic [2:0] w_aluctl;

    assign w_last = (r_cnt == LAST_CNT);
    // Reset is folded in so a stuck-at-FETCH reset never fires IRWrite/PCWrite.
    assign w_gate = EN & RESET;

`ifdef MULTICYCLE_CTRL_BNE_EN
    assign w_beq_take = (bus.funct3 == 3'b001) ? ~bus.Zero : bus.Zero;
`else
    assign w_beq_take = bus.Zero;
`endif

    alu_decoder u_alu_decoder (
        .i_is_rtype    (r_state == S_EXECUTER),
        .i_funct3      (bus.funct3),
        .i_funct7      (bus.funct7),
        .o_alu_control (w_dec_alu),
        .o_illegal     (w_dec_illegal)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_FETCH;
            r_cnt   <= 4'd0;
        end else if (EN) begin
            r_state <= w_next;
            r_cnt   <= (w_next == r_state) ? r_cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pcwrite   = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_illegal   = 1'b0;
        w_adrsrc    = ADR_PC;
        w_resultsrc = RES_ALUOUT;
        w_srca      = SRCA_PC;
        w_srcb      = SRCB_WD;
        w_aluctl    = ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_srcb      = SRCB_FOUR;
                w_resultsrc = RES_ALURES;
                w_irwrite   = w_last;
                w_pcwrite   = w_last;
                if (w_last) w_next = S_DECODE;
            end
            S_DECODE: begin
                w_srca = SRCA_OLDPC;
                w_srcb = SRCB_IMM;
                case (bus.OP)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BR:        w_next = S_BEQ;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_srca = SRCA_REG;
                w_srcb = SRCB_IMM;
                w_next = (bus.OP == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adrsrc = ADR_RESULT;
                if (w_last) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_resultsrc = RES_DATA;
                w_regwrite  = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adrsrc   = ADR_RESULT;
                w_memwrite = w_last;
                if (w_last) w_next = S_FETCH;
            end
            S_EXECUTER, S_EXECUTEI: begin
                w_srca    = SRCA_REG;
                w_srcb    = (r_state == S_EXECUTEI) ? SRCB_IMM : SRCB_WD;
                w_aluctl  = w_dec_alu;
                w_illegal = w_dec_illegal;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_next     = S_FETCH;
            end
            S_BEQ: begin
                w_srca    = SRCA_REG;
                w_aluctl  = ALU_SUB;
                w_pcwrite = w_beq_take;
                w_next    = S_FETCH;
            end
            S_JAL: begin
                w_srca    = SRCA_OLDPC;
                w_srcb    = SRCB_FOUR;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign bus.PCWrite      = w_pcwrite  & w_gate;
    assign bus.IRWrite      = w_irwrite  & w_gate;
    assign bus.RegWrite     = w_regwrite & w_gate;
    assign bus.MemWrite     = w_memwrite & w_gate;
    // Gated so a stalled DECODE/EXECUTE still yields a single pulse.
    assign bus.IllegalInstr = w_illegal  & w_gate;
    assign bus.AdrSrc       = w_adrsrc;
    assign bus.ResultSrc    = w_resultsrc;
    assign bus.ALUSrcA      = w_srca;
    assign bus.ALUSrcB      = w_srcb;
    assign bus.ALUControl   = w_aluctl;
    assign bus.ImmSrc       = imm_src(bus.OP);
    assign bus.State        = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller at MEM_LATENCY 1 and 3: directed cases plus
// random instruction streams with random stalls, checked against a state-sequence model.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BR = 7'b1100011;

    typedef struct packed {
        logic pcw; logic adr; logic memw; logic irw; logic regw;
        logic [1:0] res; logic [1:0] srca; logic [1:0] srcb; logic [1:0] imm;
        logic [2:0] alu; logic ill;
    } out_t;

    logic CLK = 1'b0;
    logic RESET, EN;
    int   checks = 0;
    int   errors = 0;
    int   sel = 1;

    always #5 CLK = ~CLK;

    multicycle_controller_if if1();
    multicycle_controller_if if3();

    multicycle_controller #(.MEM_LATENCY(1)) dut1 (.CLK(CLK), .RESET(RESET), .EN(EN), .bus(if1));
    multicycle_controller #(.MEM_LATENCY(3)) dut3 (.CLK(CLK), .RESET(RESET), .EN(EN), .bus(if3));

    out_t obs1, obs3;
    assign obs1 = {if1.PCWrite, if1.AdrSrc, if1.MemWrite, if1.IRWrite, if1.RegWrite, if1.ResultSrc,
                   if1.ALUSrcA, if1.ALUSrcB, if1.ImmSrc, if1.ALUControl, if1.IllegalInstr};
    assign obs3 = {if3.PCWrite, if3.AdrSrc, if3.MemWrite, if3.IRWrite, if3.RegWrite, if3.ResultSrc,
                   if3.ALUSrcA, if3.ALUSrcB, if3.ImmSrc, if3.ALUControl, if3.IllegalInstr};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected control outputs for one cycle, straight from the per-state output table.
    function automatic out_t exp_out(input state_t s, input bit fin, input bit en,
                                     input logic [6:0] op, input logic [2:0] f3,
                                     input logic f7, input logic z);
        out_t o;
        o = '0;
        case (op)
            IT: o.imm = 2'b00;
            SW: o.imm = 2'b01;
            BR: o.imm = 2'b10;
            JL: o.imm = 2'b11;
            default: o.imm = 2'b00;
        endcase
        case (s)
            S_FETCH:    begin o.srcb = 2'b10; o.res = 2'b10; o.irw = fin; o.pcw = fin; end
            S_DECODE:   begin o.srca = 2'b01; o.srcb = 2'b01;
                              o.ill = !(op inside {LW, SW, RT, IT, JL, BR}); end
            S_MEMADR:   begin o.srca = 2'b10; o.srcb = 2'b01; end
            S_MEMREAD:  o.adr = 1'b1;
            S_MEMWB:    begin o.res = 2'b01; o.regw = 1'b1; end
            S_MEMWRITE: begin o.adr = 1'b1; o.memw = fin; end
            S_EXECUTER, S_EXECUTEI: begin
                o.srca = 2'b10;
                o.srcb = (s == S_EXECUTEI) ? 2'b01 : 2'b00;
                case (f3)
                    3'b000:  o.alu = (s == S_EXECUTER && f7) ? 3'b001 : 3'b000;
                    3'b010:  o.alu = 3'b101;
                    3'b110:  o.alu = 3'b011;
                    3'b111:  o.alu = 3'b010;
                    default: o.ill = 1'b1;
                endcase
            end
            S_ALUWB:    o.regw = 1'b1;
            S_BEQ: begin
                o.srca = 2'b10; o.alu = 3'b001; o.pcw = z;
`ifdef MULTICYCLE_CTRL_BNE_EN
                if (f3 == 3'b001) o.pcw = !z;
`endif
            end
            S_JAL:      begin o.srca = 2'b01; o.srcb = 2'b10; o.pcw = 1'b1; end
            default: ;
        endcase
        if (!en) begin
            o.pcw = 1'b0; o.irw = 1'b0; o.regw = 1'b0; o.memw = 1'b0; o.ill = 1'b0;
        end
        return o;
    endfunction

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        if1.OP = op; if1.funct3 = f3; if1.funct7 = f7; if1.Zero = z;
        if3.OP = op; if3.funct3 = f3; if3.funct7 = f7; if3.Zero = z;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    // Runs one instruction on the selected DUT from FETCH back to (but excluding) the next FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input bit rnd_stall, input int hold_st,
                             input bit rst_memw);
        state_t q[$];
        int     lat, stalls;
        bit     fin;
        out_t   obs;
        logic [3:0] st;
        lat = (sel == 1) ? 1 : 3;
        repeat (lat) q.push_back(S_FETCH);
        q.push_back(S_DECODE);
        case (op)
            LW: begin q.push_back(S_MEMADR); repeat (lat) q.push_back(S_MEMREAD); q.push_back(S_MEMWB); end
            SW: begin q.push_back(S_MEMADR); repeat (lat) q.push_back(S_MEMWRITE); end
            RT: begin q.push_back(S_EXECUTER); q.push_back(S_ALUWB); end
            IT: begin q.push_back(S_EXECUTEI); q.push_back(S_ALUWB); end
            JL: begin q.push_back(S_JAL); q.push_back(S_ALUWB); end
            BR: q.push_back(S_BEQ);
            default: ;
        endcase
        set_in(op, f3, f7, z);
        for (int i = 0; i < q.size(); i++) begin
            fin = (i == q.size() - 1) || (q[i+1] != q[i]);
            stalls = 0;
            if (rnd_stall && $urandom_range(0, 3) == 0) stalls = $urandom_range(1, 2);
            if (int'(q[i]) == hold_st) stalls = 2;
            for (int k = 0; k <= stalls; k++) begin
                EN = (k == stalls);
                #1;
                obs = (sel == 1) ? obs1 : obs3;
                st  = (sel == 1) ? if1.State : if3.State;
                check($sformatf("state op=%b step=%0d", op, i), 32'(st), 32'(q[i]));
                check($sformatf("outs op=%b f3=%b step=%0d en=%0d", op, f3, i, EN),
                      32'(obs), 32'(exp_out(q[i], fin, EN, op, f3, f7, z)));
                if (rst_memw && EN && q[i] == S_MEMWRITE && fin) begin
                    RESET = 1'b0;
                    #1;
                    obs = (sel == 1) ? obs1 : obs3;
                    st  = (sel == 1) ? if1.State : if3.State;
                    check("reset_in_memwrite MemWrite", 32'(obs.memw), 32'd0);
                    check("reset_in_memwrite State", 32'(st), 32'(S_FETCH));
                    @(negedge CLK);
                    RESET = 1'b1;
                    return;
                end
                @(negedge CLK);
            end
        end
    endtask

    task automatic run_random(input int n);
        logic [6:0] ops [7];
        ops = '{LW, SW, RT, IT, JL, BR, 7'b0};
        for (int i = 0; i < n; i++) begin
            ops[6] = 7'($urandom);
            run_instr(ops[$urandom_range(0, 6)], 3'($urandom), 1'($urandom), 1'($urandom),
                      1'b1, -1, 1'b0);
        end
    endtask

    initial begin
        RESET = 1'b0;
        EN    = 1'b1;
        set_in(7'b0, 3'b0, 1'b0, 1'b0);
        #1;
        check("reset State lat1", 32'(if1.State), 32'(S_FETCH));
        check("reset outs lat1", 32'(obs1), 32'(exp_out(S_FETCH, 1'b1, 1'b0, 7'b0, 3'b0, 1'b0, 1'b0)));
        check("reset State lat3", 32'(if3.State), 32'(S_FETCH));
        check("reset outs lat3", 32'(obs3), 32'(exp_out(S_FETCH, 1'b0, 1'b0, 7'b0, 3'b0, 1'b0, 1'b0)));
        @(negedge CLK);
        RESET = 1'b1;

        sel = 1;
        run_instr(LW, 3'b010, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_instr(RT, 3'b000, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        run_instr(RT, 3'b000, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_instr(IT, 3'b000, 1'b1, 1'b0, 1'b0, -1, 1'b0);
        run_instr(IT, 3'b001, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_instr(RT, 3'b111, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_instr(BR, 3'b000, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        run_instr(BR, 3'b000, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_instr(BR, 3'b001, 1'b0, 1'b1, 1'b0, -1, 1'b0);
        run_instr(BR, 3'b001, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_instr(JL, 3'b000, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_instr(LW, 3'b010, 1'b0, 1'b0, 1'b0, int'(S_MEMWB), 1'b0);

        do_reset();
        sel = 3;
        run_instr(SW, 3'b010, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        run_instr(SW, 3'b010, 1'b0, 1'b0, 1'b0, int'(S_FETCH), 1'b0);
        run_instr(SW, 3'b010, 1'b0, 1'b0, 1'b0, -1, 1'b1);
        run_random(40);

        do_reset();
        sel = 1;
        run_random(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
